acq_block_sequencer: RTL and testbench
======================================

# acq_block_sequencer

Capture sequencer for the DAQ acquisition path. It sits between the wire-in control endpoints, the sample source (ramp/CIC), the transfer FIFO and the block-throttled pipe-out. On command it flushes the FIFO and runs the source for a programmed number of samples. It gates FIFO writes, pads the tail to a whole pipe block, and raises `ep_ready` only when a full block is buffered.

## Interface
- `BLOCK_WORDS`, 256: words per pipe block; power of two, 2..FIFO_DEPTH
- `FIFO_DEPTH`, 1024: transfer FIFO depth in words
- `LVL_W`, 11: width of `fifo_level` (log2(FIFO_DEPTH)+1)

Ports:
- `clock`  in  1  single clock for the whole block
- `reset`  in  1  synchronous, active-high
- `start`  in  1  capture request; sampled every cycle
- `abort`  in  1  stop capture, return to idle
- `sample_count`  in  16  samples to capture; 0 = free-run until abort
- `src_valid`  in  1  source has a sample this cycle
- `fifo_full`  in  1  FIFO full
- `fifo_level`  in  LVL_W  FIFO occupancy in words
- `ep_read`  in  1  pipe pops one word this cycle
- `src_enable`  out  1  enable to sample source
- `fifo_wr_en`  out  1  FIFO write strobe
- `pad_sel`  out  1  datapath writes 16'h0000 instead of the sample
- `fifo_flush`  out  1  one-cycle FIFO clear
- `ep_ready`  out  1  full block available to the pipe
- `busy`  out  1  state ≠ IDLE/DONE
- `done`  out  1  capture finished and drained; sticky until next accepted start
- `overflow`  out  1  sticky: sample dropped on full FIFO
- `underrun`  out  1  sticky: `ep_read` with `fifo_level`==0
- `words_written`  out  16  data+pad words written this capture
- `blocks_read`  out  16  completed blocks read; wraps at 2^16

## Operation
- States: IDLE, ARM, CAPTURE, PAD, DRAIN, DONE.
- IDLE/DONE + `start`:
  - latch `sample_count` as target
  - clear `done`, `overflow`, `underrun`, `words_written`, `blk_rd_cnt`
  - go to ARM
- `start` in ARM/CAPTURE/PAD/DRAIN is ignored.
- ARM:
  - `fifo_flush`=1 on its first cycle only
  - advance to CAPTURE on the first cycle after the flush with `fifo_level`==0
- CAPTURE:
  - `src_enable`=1
  - `fifo_wr_en` = `src_valid` & ~`fifo_full`
  - `src_valid` & `fifo_full` sets `overflow`; the sample is dropped and not counted
  - when target≠0 and the write making `words_written`==target occurs, go to PAD next cycle
- PAD:
  - `src_enable`=0; `pad_sel`=1
  - `fifo_wr_en` = ~`fifo_full`
  - `words_written` counts pad writes
  - skip or leave PAD once `words_written` mod BLOCK_WORDS == 0, then go to DRAIN
- DRAIN: wait for `fifo_level`==0 and `blk_rd_cnt`==0, then go to DONE and set `done`=1.
- Block tracking:
  - `blk_rd_cnt` increments on `ep_read`
  - at BLOCK_WORDS-1 + `ep_read` it wraps to 0 and `blocks_read` increments
  - `ep_read` with `fifo_level`==0 sets `underrun`; the count still advances
- `ep_ready` (registered) = (`fifo_level` ≥ BLOCK_WORDS) & (`blk_rd_cnt`==0), in any state except ARM.
- `abort` from any state:
  - next cycle: state IDLE, `src_enable`=0, `fifo_flush`=1 for one cycle
  - `blk_rd_cnt` cleared; `done` not set
- Priority: `reset` > `abort` > `start`.
- `words_written` saturates at 16'hFFFF in free-run.

## Timing
- Reset: all outputs 0; state IDLE; counters 0.
- `start` at cycle t → ARM at t+1 with `fifo_flush`=1 at t+1; earliest CAPTURE at t+2.
- `src_enable`, `pad_sel`, `busy`, `done`, `ep_ready` are registered.
- `fifo_wr_en` is combinational from the registered state, `src_valid` and `fifo_full`: zero latency.
- Last data write at cycle n → PAD at n+1 → first pad write at n+1.
- DONE is entered the cycle after the DRAIN condition holds.
- `ep_ready` lags `fifo_level`/`ep_read` by one cycle.
- `ep_ready` drops the cycle after the first `ep_read` of a block.

## Configuration
- `ACQ_SEQ_PAD_EN` defined: PAD state as above; every capture ends on a block boundary.
- `ACQ_SEQ_PAD_EN` undefined:
  - PAD state absent; `pad_sel` tied 0
  - CAPTURE goes straight to DRAIN
  - DRAIN completes when `fifo_level` < BLOCK_WORDS and `blk_rd_cnt`==0, then issues a one-cycle `fifo_flush` to discard the partial block, then enters DONE

## Test plan
- BLOCK_WORDS=256, `sample_count`=512, `src_valid`=1 continuous, host reads each block when `ep_ready` → `words_written`=512, `pad_sel` never 1, `blocks_read`=2, `done`=1, `overflow`=0.
- `sample_count`=300, PAD_EN defined → 212 pad writes with `pad_sel`=1, `words_written`=512, `blocks_read`=2 after reads, `done`=1.
- Same as above with PAD_EN undefined → `words_written`=300, `blocks_read`=1, one `fifo_flush` before DONE.
- FIFO_DEPTH=1024, no reads, `sample_count`=1100 → `fifo_full` reached, `overflow`=1, `words_written` stops at 1024 until reads resume.
- `abort` mid-CAPTURE at `words_written`=100 → IDLE next cycle, `src_enable`=0, `fifo_flush` pulse, `done`=0; `start` pulsed during CAPTURE earlier is ignored.
- `ep_read` pulsed in IDLE with empty FIFO → `underrun`=1; `reset` → all outputs 0.

Source files
------------

// File: rtl/acq_block_sequencer.sv
// acq_block_sequencer: gates sample writes into the transfer FIFO, squares the capture tail to a pipe block and throttles pipe-out per block.
// Latency: start -> fifo_flush next cycle, capture at the earliest two cycles after start; fifo_wr_en is zero-latency from state/src_valid/fifo_full.
// Backpressure: writes stall on fifo_full (capture samples dropped, overflow flagged); ep_ready only when a whole block is buffered and no block is mid-read.
//
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   start, abort         capture request / cancel (abort wins over start)
//   sample_count         samples per capture, 0 = free-run until abort
//   src_valid            sample source handshake; src_enable runs the source
//   fifo_full/level      transfer FIFO status; fifo_wr_en/pad_sel/fifo_flush control it
//   ep_read, ep_ready    pipe-out pop strobe and block-available flag
//   busy, done           activity / sticky completion
//   overflow, underrun   sticky error flags
//   words_written        data + pad words written in this capture (saturating)
//   blocks_read          completed blocks popped by the pipe (wrapping)
//
// Build option ACQ_SEQ_PAD_EN:
//   defined   - a PAD state tops the capture up with zero words to a block boundary.
//   undefined - no PAD; the trailing partial block is discarded with a FIFO flush.

module acq_block_sequencer #(
    parameter int BLOCK_WORDS = 256,
    parameter int FIFO_DEPTH  = 1024,
    parameter int LVL_W       = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      sample_count,
    input  logic             src_valid,
    input  logic             fifo_full,
    input  logic [LVL_W-1:0] fifo_level,
    input  logic             ep_read,
    output logic             src_enable,
    output logic             fifo_wr_en,
    output logic             pad_sel,
    output logic             fifo_flush,
    output logic             ep_ready,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic             underrun,
    output logic [15:0]      words_written,
    output logic [15:0]      blocks_read
);

    localparam int                 CNT_W     = $clog2(BLOCK_WORDS);
    localparam logic [LVL_W-1:0]   BLK_LVL   = LVL_W'(BLOCK_WORDS);
    localparam logic [LVL_W-1:0]   DEPTH_LVL = LVL_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(BLOCK_WORDS - 1);

`ifdef ACQ_SEQ_PAD_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PAD     = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;
`endif

    state_t            state_q, state_d;
    logic [15:0]       target_q, target_d;
    logic [15:0]       words_written_q, words_written_d;
    logic [CNT_W-1:0]  blk_rd_cnt_q, blk_rd_cnt_d;
    logic [15:0]       blocks_read_q, blocks_read_d;
    logic              done_q, done_d;
    logic              overflow_q, overflow_d;
    logic              underrun_q, underrun_d;
    logic              src_enable_q, src_enable_d;
    logic              fifo_flush_q, fifo_flush_d;
    logic              ep_ready_q, ep_ready_d;
    logic              busy_q, busy_d;
`ifdef ACQ_SEQ_PAD_EN
    logic              pad_sel_q, pad_sel_d;
`endif

    logic              full_eff;
    logic              start_acc;
    logic [15:0]       ww_inc;
    logic              rd_pop;
    logic [LVL_W-1:0]  level_after;

    // A level at depth is treated as full too, so a late fifo_full never lets a write through.
    assign full_eff  = fifo_full | (fifo_level >= DEPTH_LVL);
    // Start is only taken from a resting state and never on the same cycle as abort.
    assign start_acc = start & ~abort & ((state_q == ST_IDLE) | (state_q == ST_DONE));
    // Saturating count: free-run captures can exceed 16 bits.
    assign ww_inc    = (words_written_q == 16'hFFFF) ? words_written_q : words_written_q + 16'd1;

    // Write strobe is decoded straight from the registered state so the source sees zero latency.
    always_comb begin
        fifo_wr_en = 1'b0;
        case (state_q)
            ST_CAPTURE: fifo_wr_en = src_valid & ~full_eff;
`ifdef ACQ_SEQ_PAD_EN
            ST_PAD:     fifo_wr_en = ~full_eff;
`endif
            default:    fifo_wr_en = 1'b0;
        endcase
    end

    always_comb begin
        state_d         = state_q;
        target_d        = target_q;
        words_written_d = words_written_q;
        blk_rd_cnt_d    = blk_rd_cnt_q;
        blocks_read_d   = blocks_read_q;
        done_d          = done_q;
        overflow_d      = overflow_q;
        underrun_d      = underrun_q;
        fifo_flush_d    = 1'b0;

        if (fifo_wr_en) begin
            words_written_d = ww_inc;
        end

        if ((state_q == ST_CAPTURE) && src_valid && full_eff) begin
            overflow_d = 1'b1;
        end

        // Block tracking runs in every state; an empty-FIFO pop is flagged but still counted
        // so the pipe and this counter stay in step.
        if (ep_read) begin
            if (blk_rd_cnt_q == CNT_LAST) begin
                blk_rd_cnt_d  = '0;
                blocks_read_d = blocks_read_q + 16'd1;
            end else begin
                blk_rd_cnt_d  = blk_rd_cnt_q + CNT_W'(1);
            end
            if (fifo_level == '0) begin
                underrun_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_acc) begin
                    target_d        = sample_count;
                    done_d          = 1'b0;
                    overflow_d      = 1'b0;
                    underrun_d      = 1'b0;
                    words_written_d = '0;
                    blk_rd_cnt_d    = '0;
                    fifo_flush_d    = 1'b1;
                    state_d         = ST_ARM;
                end
            end

            // The flush cycle may already see an empty FIFO; otherwise wait for the
            // cleared level to come back before enabling the source.
            ST_ARM: begin
                if (fifo_level == '0) begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                if (fifo_wr_en && (target_q != '0) && (ww_inc == target_q)) begin
`ifdef ACQ_SEQ_PAD_EN
                    // Already block-aligned: nothing to pad.
                    state_d = (ww_inc[CNT_W-1:0] == '0) ? ST_DRAIN : ST_PAD;
`else
                    state_d = ST_DRAIN;
`endif
                end
            end

`ifdef ACQ_SEQ_PAD_EN
            ST_PAD: begin
                if (fifo_wr_en && (ww_inc[CNT_W-1:0] == '0)) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                if ((fifo_level == '0) && (blk_rd_cnt_q == '0)) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
`else
            // Whatever is left below a block can never be piped out; drop it with the flush.
            ST_DRAIN: begin
                if ((fifo_level < BLK_LVL) && (blk_rd_cnt_q == '0)) begin
                    state_d      = ST_DONE;
                    done_d       = 1'b1;
                    fifo_flush_d = 1'b1;
                end
            end
`endif

            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything above except the accounting of writes and reads
        // that physically happened this cycle.
        if (abort) begin
            state_d      = ST_IDLE;
            fifo_flush_d = 1'b1;
            blk_rd_cnt_d = '0;
            done_d       = done_q;
        end
    end

    // Registered status outputs follow the next state so they line up with it.
    always_comb begin
        rd_pop       = ep_read & (fifo_level != '0);
        // Account for this cycle's pop: a block that just finished must not re-advertise
        // a full block from the stale pre-pop level.
        level_after  = fifo_level - {{(LVL_W-1){1'b0}}, rd_pop};
        src_enable_d = (state_d == ST_CAPTURE);
        busy_d       = (state_d != ST_IDLE) & (state_d != ST_DONE);
        // Around a flush the incoming level is stale, so hold ep_ready low then.
        ep_ready_d   = (state_d != ST_ARM) & ~fifo_flush_d & ~fifo_flush_q &
                       (level_after >= BLK_LVL) & (blk_rd_cnt_d == '0);
`ifdef ACQ_SEQ_PAD_EN
        pad_sel_d    = (state_d == ST_PAD);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            target_q        <= '0;
            words_written_q <= '0;
            blk_rd_cnt_q    <= '0;
            blocks_read_q   <= '0;
            done_q          <= 1'b0;
            overflow_q      <= 1'b0;
            underrun_q      <= 1'b0;
            src_enable_q    <= 1'b0;
            fifo_flush_q    <= 1'b0;
            ep_ready_q      <= 1'b0;
            busy_q          <= 1'b0;
`ifdef ACQ_SEQ_PAD_EN
            pad_sel_q       <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            target_q        <= target_d;
            words_written_q <= words_written_d;
            blk_rd_cnt_q    <= blk_rd_cnt_d;
            blocks_read_q   <= blocks_read_d;
            done_q          <= done_d;
            overflow_q      <= overflow_d;
            underrun_q      <= underrun_d;
            src_enable_q    <= src_enable_d;
            fifo_flush_q    <= fifo_flush_d;
            ep_ready_q      <= ep_ready_d;
            busy_q          <= busy_d;
`ifdef ACQ_SEQ_PAD_EN
            pad_sel_q       <= pad_sel_d;
`endif
        end
    end

    assign src_enable    = src_enable_q;
    assign fifo_flush    = fifo_flush_q;
    assign ep_ready      = ep_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign overflow      = overflow_q;
    assign underrun      = underrun_q;
    assign words_written = words_written_q;
    assign blocks_read   = blocks_read_q;
`ifdef ACQ_SEQ_PAD_EN
    assign pad_sel       = pad_sel_q;
`else
    assign pad_sel       = 1'b0;
`endif

endmodule

// File: tb/tb_acq_block_sequencer.sv
`timescale 1ns/1ps
module tb_acq_block_sequencer;

    localparam int BW    = 256;
    localparam int DEPTH = 1024;
    localparam int LW    = 11;
`ifdef ACQ_SEQ_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [15:0]   sample_count = '0;
    logic          src_valid = 1'b0;
    logic          fifo_full;
    logic [LW-1:0] fifo_level;
    logic          ep_read;
    logic          src_enable, fifo_wr_en, pad_sel, fifo_flush, ep_ready;
    logic          busy, done, overflow, underrun;
    logic [15:0]   words_written, blocks_read;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    acq_block_sequencer #(.BLOCK_WORDS(BW), .FIFO_DEPTH(DEPTH), .LVL_W(LW)) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .sample_count(sample_count), .src_valid(src_valid), .fifo_full(fifo_full),
        .fifo_level(fifo_level), .ep_read(ep_read), .src_enable(src_enable),
        .fifo_wr_en(fifo_wr_en), .pad_sel(pad_sel), .fifo_flush(fifo_flush),
        .ep_ready(ep_ready), .busy(busy), .done(done), .overflow(overflow),
        .underrun(underrun), .words_written(words_written), .blocks_read(blocks_read)
    );

    // Behavioural transfer FIFO: occupancy only.
    logic [LW-1:0] lvl_q = '0;
    assign fifo_level = lvl_q;
    assign fifo_full  = (lvl_q == LW'(DEPTH));

    always @(posedge clock) begin
        int nxt;
        nxt = int'(lvl_q);
        if (fifo_wr_en && nxt < DEPTH) nxt++;
        if (ep_read && lvl_q != '0) nxt--;
        if (reset || fifo_flush) nxt = 0;
        lvl_q <= LW'(nxt);
    end

    // Observed write traffic, split into sample and pad words.
    int data_wr = 0;
    int pad_wr  = 0;
    always @(posedge clock) begin
        if (!reset && fifo_wr_en) begin
            if (pad_sel) pad_wr++;
            else         data_wr++;
        end
    end

    // Host: once ep_ready is seen, pops one whole block, optionally with idle gaps.
    logic host_en  = 1'b0;
    int   host_gap = 0;
    int   host_rem = 0;
    logic host_rd  = 1'b0;
    logic man_rd   = 1'b0;
    assign ep_read = host_rd | man_rd;

    always @(negedge clock) begin
        host_rd = 1'b0;
        if (!host_en) begin
            host_rem = 0;
        end else begin
            if (host_rem == 0 && ep_ready) host_rem = BW;
            if (host_rem > 0 && $urandom_range(0, 99) >= host_gap) begin
                host_rd  = 1'b1;
                host_rem = host_rem - 1;
            end
        end
    end

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1; start = 1'b0; abort = 1'b0; src_valid = 1'b0;
        man_rd = 1'b0; host_en = 1'b0; sample_count = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        n_checks++;
        if ({src_enable, fifo_wr_en, pad_sel, fifo_flush, ep_ready, busy, done, overflow, underrun} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0", {src_enable, fifo_wr_en, pad_sel, fifo_flush, ep_ready, busy, done, overflow, underrun});
        end
        n_checks++;
        if (words_written !== 16'd0) begin
            n_fail++; $display("FAIL reset_words_written: got %0d expected 0", words_written);
        end
        n_checks++;
        if (blocks_read !== 16'd0) begin
            n_fail++; $display("FAIL reset_blocks_read: got %0d expected 0", blocks_read);
        end
    endtask

    // Empty-FIFO pop in IDLE sets underrun; a following reset clears it.
    task automatic test_underrun();
        do_reset();
        @(negedge clock);
        man_rd = 1'b1;
        @(negedge clock);
        man_rd = 1'b0;
        n_checks++;
        if (underrun !== 1'b1) begin
            n_fail++; $display("FAIL underrun_set: got %b expected 1", underrun);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL underrun_idle_busy: got %b expected 0", busy);
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_checks++;
        if (underrun !== 1'b0 || done !== 1'b0 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_clears_sticky: got u=%b d=%b o=%b expected 0", underrun, done, overflow);
        end
    endtask

    // One complete capture from reset. valid_pct: source duty; gap: host idle percent;
    // stall: cycles the host stays off after start (FIFO allowed to fill).
    task automatic test_capture(input int n, input int valid_pct, input int gap, input int stall, input bit exp_ovf);
        int exp_ww, exp_blk, exp_pad, exp_flush;
        int d0, p0, flushes, cyc;
        bit finished;
        exp_ww    = PAD_EN ? ((n + BW - 1) / BW) * BW : n;
        exp_blk   = PAD_EN ? (n + BW - 1) / BW : n / BW;
        exp_pad   = exp_ww - n;
        exp_flush = PAD_EN ? 0 : 1;

        do_reset();
        host_gap = gap;
        host_en  = (stall == 0);
        d0 = data_wr;
        p0 = pad_wr;
        sample_count = 16'(n);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_checks++;
        if (fifo_flush !== 1'b1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL arm_flush_n%0d: got flush=%b busy=%b expected 1 1", n, fifo_flush, busy);
        end
        src_valid = ($urandom_range(1, 100) <= valid_pct);
        @(negedge clock);
        n_checks++;
        if (src_enable !== 1'b1) begin
            n_fail++; $display("FAIL capture_at_t2_n%0d: got src_enable=%b expected 1", n, src_enable);
        end

        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                src_valid = ($urandom_range(1, 100) <= valid_pct);
                @(negedge clock);
            end
            n_checks++;
            if (words_written !== 16'(DEPTH) || fifo_full !== 1'b1) begin
                n_fail++; $display("FAIL stall_ww: got ww=%0d full=%b expected %0d 1", words_written, fifo_full, DEPTH);
            end
            n_checks++;
            if (overflow !== 1'b1 || ep_ready !== 1'b1 || done !== 1'b0) begin
                n_fail++; $display("FAIL stall_flags: got ovf=%b rdy=%b done=%b expected 1 1 0", overflow, ep_ready, done);
            end
            host_en = 1'b1;
        end

        flushes  = 0;
        finished = 1'b0;
        cyc      = 0;
        while (!finished && cyc < 20000) begin
            src_valid = ($urandom_range(1, 100) <= valid_pct);
            @(negedge clock);
            if (fifo_flush) flushes++;
            if (done) finished = 1'b1;
            cyc++;
        end
        src_valid = 1'b0;

        n_checks++;
        if (!finished) begin
            n_fail++; $display("FAIL done_timeout_n%0d: got done=%b expected 1 within 20000 cycles", n, done);
        end
        n_checks++;
        if (words_written !== 16'(exp_ww)) begin
            n_fail++; $display("FAIL words_written_n%0d: got %0d expected %0d", n, words_written, exp_ww);
        end
        n_checks++;
        if (blocks_read !== 16'(exp_blk)) begin
            n_fail++; $display("FAIL blocks_read_n%0d: got %0d expected %0d", n, blocks_read, exp_blk);
        end
        n_checks++;
        if (data_wr - d0 != n) begin
            n_fail++; $display("FAIL data_writes_n%0d: got %0d expected %0d", n, data_wr - d0, n);
        end
        n_checks++;
        if (pad_wr - p0 != exp_pad) begin
            n_fail++; $display("FAIL pad_writes_n%0d: got %0d expected %0d", n, pad_wr - p0, exp_pad);
        end
        n_checks++;
        if (flushes != exp_flush) begin
            n_fail++; $display("FAIL tail_flush_n%0d: got %0d expected %0d", n, flushes, exp_flush);
        end
        n_checks++;
        if (overflow !== exp_ovf || underrun !== 1'b0) begin
            n_fail++; $display("FAIL sticky_n%0d: got ovf=%b und=%b expected %b 0", n, overflow, underrun, exp_ovf);
        end
        n_checks++;
        if (busy !== 1'b0 || src_enable !== 1'b0) begin
            n_fail++; $display("FAIL idle_after_n%0d: got busy=%b src_en=%b expected 0 0", n, busy, src_enable);
        end
        @(negedge clock);
        n_checks++;
        if (fifo_level !== '0 || done !== 1'b1) begin
            n_fail++; $display("FAIL final_level_n%0d: got level=%0d done=%b expected 0 1", n, fifo_level, done);
        end
        host_en = 1'b0;
    endtask

    // Start during CAPTURE is ignored; abort at 100 words returns to IDLE with a flush.
    task automatic test_abort();
        int cyc;
        do_reset();
        host_gap = 0;
        host_en  = 1'b1;
        sample_count = 16'd1000;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        src_valid = 1'b1;
        cyc = 0;
        while (words_written != 16'd20 && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        n_checks++;
        if (words_written !== 16'd21 || fifo_flush !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL start_ignored: got ww=%0d flush=%b busy=%b expected 21 0 1", words_written, fifo_flush, busy);
        end
        cyc = 0;
        while (words_written != 16'd100 && cyc < 300) begin
            @(negedge clock);
            cyc++;
        end
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        src_valid = 1'b0;
        host_en = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || src_enable !== 1'b0 || fifo_flush !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL abort_idle: got busy=%b src_en=%b flush=%b done=%b expected 0 0 1 0", busy, src_enable, fifo_flush, done);
        end
        @(negedge clock);
        n_checks++;
        if (fifo_flush !== 1'b0 || fifo_level !== '0 || fifo_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL abort_flush_once: got flush=%b level=%0d wr=%b expected 0 0 0", fifo_flush, fifo_level, fifo_wr_en);
        end
    endtask

    initial begin
        test_reset();
        test_underrun();
        test_capture(512, 100, 0, 0, 1'b0);
        test_capture(300, 100, 0, 0, 1'b0);
        test_capture(1100, 100, 0, 1300, 1'b1);
        test_abort();
        for (int k = 0; k < 4; k++) begin
            test_capture($urandom_range(1, 700), $urandom_range(60, 100), $urandom_range(0, 50), 0, 1'b0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
